// File: rtl/filter_polyphase.sv
// filter_polyphase: time-multiplexed rational L/M polyphase FIR shared by
// NR_STREAMS interleaved streams. Every stream uses the same phase.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   enable           leave IDLE and start processing (sampled only in IDLE)
//   coef_we/addr/data  coefficient RAM write port, addr = {phase, tap}; IDLE only
//   req_in/ack_in    input handshake, one sample per stream, stream 0 first
//   data_in          signed input sample (index 0 is the MSB)
//   req_out/ack_out  output handshake, results in stream order 0..NR_STREAMS-1
//   data_out         saturated signed result
//   out_stream       stream id of data_out
//   busy             high whenever the FSM is not in IDLE

// Per-stream history shift register, TAPS deep. hist[0] is the newest sample.
module filter_polyphase_lane #(
  parameter int DWIDTH = 16,
  parameter int TAPS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic [DWIDTH-1:0]             din,
  output logic [TAPS-1:0][DWIDTH-1:0]   hist
);
  logic [TAPS-1:0][DWIDTH-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      for (int t = TAPS-1; t > 0; t--) hist_d[t] = hist_q[t-1];
      hist_d[0] = din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist_q <= '0;
    else      hist_q <= hist_d;
  end

  assign hist = hist_q;
endmodule

module filter_polyphase #(
  parameter int DWIDTH         = 16,
  parameter int L              = 160,
  parameter int L_LOG          = 8,
  parameter int M              = 147,
  parameter int M_LOG          = 8,
  parameter int TAPS           = 4,
  parameter int TAPS_LOG       = 2,
  parameter int NR_STREAMS     = 16,
  parameter int NR_STREAMS_LOG = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      coef_we,
  input  logic [L_LOG+TAPS_LOG-1:0] coef_addr,
  input  logic [DWIDTH-1:0]         coef_data,
  output logic                      req_in,
  input  logic                      ack_in,
  input  logic [0:DWIDTH-1]         data_in,
  output logic                      req_out,
  input  logic                      ack_out,
  output logic [0:DWIDTH-1]         data_out,
  output logic [NR_STREAMS_LOG-1:0] out_stream,
  output logic                      busy
);
  // phase < L before +M, so phase+M < L+M always fits in max(L_LOG,M_LOG)+1 bits
  localparam int PW     = ((L_LOG > M_LOG) ? L_LOG : M_LOG) + 1;
  localparam int AW     = 2*DWIDTH + TAPS_LOG;
  localparam int CDEPTH = 1 << (L_LOG + TAPS_LOG);

  localparam logic [PW-1:0]             L_C    = PW'(L);
  localparam logic [PW-1:0]             M_C    = PW'(M);
  localparam logic [NR_STREAMS_LOG-1:0] S_LAST = NR_STREAMS_LOG'(NR_STREAMS-1);
  localparam logic [TAPS_LOG-1:0]       T_LAST = TAPS_LOG'(TAPS-1);
  localparam logic signed [AW-1:0]      SMAX   = {{(AW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0]      SMIN   = ~SMAX;

  typedef enum logic [1:0] {IDLE, READ, MAC, OUT} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               phase_q, phase_d, phase_tmp;
  logic [NR_STREAMS_LOG-1:0]   s_q, s_d;
  logic [TAPS_LOG-1:0]         tap_q, tap_d;
  logic signed [AW-1:0]        acc_q, acc_d;
  logic [DWIDTH-1:0]           dout_q, dout_d;
  logic [NR_STREAMS_LOG-1:0]   ostr_q, ostr_d;
  logic                        req_in_q, req_in_d;
  logic                        req_out_q, req_out_d;

  logic in_xfer, out_xfer;
  assign in_xfer  = req_in_q && ack_in;
  assign out_xfer = req_out_q && ack_out;

  // Coefficient RAM: no reset, contents survive rst. Asynchronous read keeps
  // the MAC at one tap per cycle without an extra pipeline stage.
  logic [DWIDTH-1:0] coef_mem [CDEPTH];
  logic [DWIDTH-1:0] coef_rd;

  always_ff @(posedge clk) begin
    if (coef_we && state_q == IDLE) coef_mem[coef_addr] <= coef_data;
  end
  assign coef_rd = coef_mem[{phase_q[L_LOG-1:0], tap_q}];

  // History lanes
  logic [NR_STREAMS-1:0]                          shift_en;
  logic [NR_STREAMS-1:0][TAPS-1:0][DWIDTH-1:0]    hist_all;
  logic [DWIDTH-1:0]                              din_w;

  assign din_w = data_in;

  always_comb begin
    shift_en = '0;
    if (in_xfer) shift_en[s_q] = 1'b1;
  end

  for (genvar g = 0; g < NR_STREAMS; g++) begin : g_lane
    filter_polyphase_lane #(.DWIDTH(DWIDTH), .TAPS(TAPS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en[g]),
      .din      (din_w),
      .hist     (hist_all[g])
    );
  end

  // MAC datapath
  logic signed [2*DWIDTH-1:0] prod;
  logic signed [AW-1:0]       acc_sum, acc_shr;
  logic [DWIDTH-1:0]          sat_val;

  assign prod    = $signed(coef_rd) * $signed(hist_all[s_q][tap_q]);
  assign acc_sum = acc_q + AW'(prod);
  assign acc_shr = acc_sum >>> (DWIDTH-1);

  always_comb begin
    if (acc_shr > SMAX)      sat_val = {1'b0, {(DWIDTH-1){1'b1}}};
    else if (acc_shr < SMIN) sat_val = {1'b1, {(DWIDTH-1){1'b0}}};
    else                     sat_val = acc_shr[DWIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      s_q       <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
      ostr_q    <= '0;
      req_in_q  <= 1'b0;
      req_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      s_q       <= s_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      ostr_q    <= ostr_d;
      req_in_q  <= req_in_d;
      req_out_q <= req_out_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    s_d       = s_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    ostr_d    = ostr_q;
    phase_tmp = '0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = READ;
          s_d     = '0;
        end
      end
      READ: begin
        if (in_xfer) begin
          if (s_q == S_LAST) begin
            // M > L can leave phase >= L, which needs another input round
            phase_tmp = (phase_q >= L_C) ? phase_q - L_C : phase_q;
            phase_d   = phase_tmp;
            s_d       = '0;
            if (phase_tmp < L_C) begin
              state_d = MAC;
              tap_d   = '0;
              acc_d   = '0;
            end
          end else begin
            s_d = s_q + NR_STREAMS_LOG'(1);
          end
        end
      end
      MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + TAPS_LOG'(1);
        if (tap_q == T_LAST) begin
          dout_d  = sat_val;
          ostr_d  = s_q;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_xfer) begin
          tap_d = '0;
          acc_d = '0;
          if (s_q != S_LAST) begin
            s_d     = s_q + NR_STREAMS_LOG'(1);
            state_d = MAC;
          end else begin
            phase_tmp = phase_q + M_C;
            phase_d   = phase_tmp;
            s_d       = '0;
            state_d   = (phase_tmp >= L_C) ? READ : MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake requests: raised the cycle after entering the
  // state, dropped the cycle after the transfer. This gives the TAPS+1
  // cycle latency from the triggering transfer to req_out.
  always_comb begin
    req_in_d  = (state_q == READ) && !in_xfer;
    req_out_d = (state_q == OUT)  && !out_xfer;
    busy      = (state_q != IDLE);
  end

  assign req_in     = req_in_q;
  assign req_out    = req_out_q;
  assign data_out   = dout_q;
  assign out_stream = ostr_q;
endmodule

// File: doc/filter_polyphase.md
Name: filter_polyphase

Overview:
- Parametrised successor to the multistream sample-rate-converter filter.
- Time-multiplexed rational L/M polyphase FIR shared across NR_STREAMS interleaved streams. All streams share one phase.
- Consumes input rounds of one sample per stream in round-robin order and emits output rounds in stream order 0..NR_STREAMS-1.
- Uses the codebase req/ack handshake on both sides and a loadable coefficient RAM.

Parameters:
DWIDTH, 16, sample and coefficient width; coefficients are Q1.(DWIDTH-1) signed
L, 160, interpolation factor (number of phases)
L_LOG, 8, bits to index a phase
M, 147, decimation factor (phase step)
M_LOG, 8, bits for M
TAPS, 4, taps per phase; must equal 2**TAPS_LOG
TAPS_LOG, 2, bits to index a tap
NR_STREAMS, 16, interleaved channel count
NR_STREAMS_LOG, 4, bits to index a stream

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
enable  in  1  leave IDLE and start processing
coef_we  in  1  coefficient write strobe
coef_addr  in  L_LOG+TAPS_LOG  write address {phase, tap}
coef_data  in  DWIDTH  coefficient value
req_in  out  1  ready to accept an input sample
ack_in  in  1  input sample valid
data_in  in  [0:DWIDTH-1]  signed sample; index 0 is the MSB
req_out  out  1  output sample valid
ack_out  in  1  output consumed
data_out  out  [0:DWIDTH-1]  signed result
out_stream  out  NR_STREAMS_LOG  stream id of data_out
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=0, async): req_in=0, req_out=0, data_out=0, out_stream=0, busy=0.
  - All history registers are cleared; phase=0; state=IDLE.
  - Coefficient RAM is not cleared.
- Handshake: a transfer completes at a clock edge where req && ack are both 1.
  - req_in and req_out are registered, held high until their transfer completes, then dropped in the next cycle.
- Coefficient writes: accepted only in IDLE. coef_we outside IDLE is ignored.
- History: per stream, TAPS samples h[s][0..TAPS-1]. An input transfer for stream s shifts h[s][t] <= h[s][t-1] and loads h[s][0] <= data_in.
- FSM states and transitions:
  - IDLE → READ when enable=1.
  - READ: req_in=1. Accepts NR_STREAMS transfers, stream 0 first. After the last one: phase <= phase-L if phase>=L.
    - If the new phase is still >= L, the FSM performs another READ round (this handles M>L).
    - Otherwise, with s=0, the FSM moves to MAC.
  - MAC: one tap per cycle for TAPS cycles: acc += c[{phase,t}] * h[s][t].
    - acc is signed, 2*DWIDTH+TAPS_LOG bits, cleared at MAC entry.
    - On the last tap, data_out <= sat(acc_final >>> (DWIDTH-1)) and out_stream <= s; then the FSM moves to OUT.
  - OUT: req_out=1 with data_out stable. On the ack_out transfer:
    - If s < NR_STREAMS-1: s++, go to MAC.
    - Else: phase <= phase+M. If the result is >= L go to READ; else, with s=0, go to MAC (same inputs, new phase).
- Latency: req_out rises exactly TAPS+1 cycles after the edge that completes the last input transfer of a round, and TAPS+1 cycles after each earlier ack_out within a round.
- Saturation: results above 2**(DWIDTH-1)-1 clamp to 0x7FFF; results below -2**(DWIDTH-1) clamp to 0x8000 (DWIDTH=16 values).
- Phase register width is max(L_LOG,M_LOG)+1 and never overflows.
- Backpressure:
  - ack_out=0 holds OUT indefinitely; req_in stays 0.
  - ack_in=0 holds READ indefinitely; req_out stays 0.
- req_in and req_out are never high in the same cycle.
- enable=0 is sampled only in IDLE; once started, the block runs until reset.
- Reset mid-operation: everything returns immediately to the reset values. A partially read round is discarded.

Test Plan:
- Reset: hold rst=0 mid-READ with ack_in=1 → req_in=0, req_out=0, data_out=0, busy=0 within the same cycle; after release the block stays in IDLE until enable=1.
- Basic (L=4, M=3, TAPS=2, NR_STREAMS=2; c[p][0]=0x4000, c[p][1]=0 for all p; inputs 1000, -2000):
  - Outputs 500/s0, -1000/s1 at phase 0, then again at phase 3.
  - Next: a READ round (phase 6→2), outputs at phase 2, then phase 5→1 READ.
- Latency/history (c[p][0]=0, c[p][1]=0x7FFF; first round inputs 100, 200):
  - First outputs are 0, 0 (h[s][1] cleared).
  - After the second round inputs 300, 400, outputs are 99, 199 (floor).
  - req_out rises TAPS+1=3 cycles after the last input transfer.
- Saturation: both taps 0x7FFF, two rounds of 0x7FFF → 0x7FFF; both taps 0x7FFF, inputs 0x8000 → 0x8000.
- Backpressure: ack_out=0 for 10 cycles in OUT → req_out=1 and data_out/out_stream stable, req_in=0; ack_in stalls in READ → req_out=0.
- Coefficient guard: coef_we pulses with coef_data=0x7FFF while busy=1 → outputs unchanged from the preloaded set; the same write in IDLE → takes effect.
